control_sequencer: RTL and testbench

Hardwired control unit that drives the one-hot bus-select, register-load, ALU-op and memory-read controls of the CPU datapath. It is the issuing end of those controls: it sequences fetch, decode and execute for a reduced instruction set. It also runs the memory request/done handshake and halts on a HALT instruction or a memory timeout. It sits beside the datapath, sees IR contents, and drives every datapath control input.

---
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the datapath/memory it steers.
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_done;

    logic [15:0] reg_sel;
    logic [15:0] reg_in;
    logic        hi_sel, low_sel, zhigh_sel, zlow_sel, pc_sel, mdr_sel, inport_sel, c_sel;
    logic        hi_in, low_in, zhigh_in, zlow_in, pc_in, mdr_in, ir_in, ry_in, rz_in, mar_in;
    logic [3:0]  alu_control;
    logic        md_read;
    logic        mem_read;
    logic        mem_write;
    logic        halted;
    logic        fault;

    // Sequencer side: observes IR/run/memory, issues every control.
    modport master (
        input  run, ir, mem_done,
        output reg_sel, reg_in,
               hi_sel, low_sel, zhigh_sel, zlow_sel, pc_sel, mdr_sel, inport_sel, c_sel,
               hi_in, low_in, zhigh_in, zlow_in, pc_in, mdr_in, ir_in, ry_in, rz_in, mar_in,
               alu_control, md_read, mem_read, mem_write, halted, fault
    );

    // Datapath/memory side: consumes controls, reports IR/run/memory status.
    modport slave (
        output run, ir, mem_done,
        input  reg_sel, reg_in,
               hi_sel, low_sel, zhigh_sel, zlow_sel, pc_sel, mdr_sel, inport_sel, c_sel,
               hi_in, low_in, zhigh_in, zlow_in, pc_in, mdr_in, ir_in, ry_in, rz_in, mar_in,
               alu_control, md_read, mem_read, mem_write, halted, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the reduced-ISA datapath,
// including the memory request/done handshake with a bounded wait.
module control_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);
    localparam int unsigned CNT_W = 8;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_INC = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    state_t             state;
    state_t             after_instr;
    logic [CNT_W-1:0]   wait_cnt;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        is_alu, is_addi, is_muldiv, is_ld, is_st, is_halt;
    logic [3:0]  alu_op;
    logic        in_wait;
    logic        timeout;
    logic        ir_unused;

    assign opcode    = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign ir_unused = ^bus.ir[14:0];

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // Instruction class and ALU op from the opcode field
    always_comb begin
        is_alu    = 1'b0;
        is_addi   = 1'b0;
        is_muldiv = 1'b0;
        is_ld     = 1'b0;
        is_st     = 1'b0;
        is_halt   = 1'b0;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_ADD:  begin is_alu = 1'b1;    alu_op = ALU_ADD; end
            OP_SUB:  begin is_alu = 1'b1;    alu_op = ALU_SUB; end
            OP_AND:  begin is_alu = 1'b1;    alu_op = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1;    alu_op = ALU_OR;  end
            OP_MUL:  begin is_muldiv = 1'b1; alu_op = ALU_MUL; end
            OP_DIV:  begin is_muldiv = 1'b1; alu_op = ALU_DIV; end
            OP_ADDI: is_addi = 1'b1;
            OP_LD:   is_ld   = 1'b1;
            OP_ST:   is_st   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Memory wait states: fetch, load read and store write
    assign in_wait     = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
    assign timeout     = in_wait && !bus.mem_done && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
    assign after_instr = bus.run ? S_T0 : S_IDLE;

    // Step sequencing and the outstanding-request counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            if (!in_wait) begin
                wait_cnt <= '0;
            end else if (!bus.mem_done) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: if (bus.run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    if (bus.mem_done)  state <= S_T2;
                    else if (timeout)  state <= S_FAULT;
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    if (is_halt)
                        state <= S_HALT;
                    else if (is_alu || is_addi || is_muldiv || is_ld || is_st)
                        state <= S_T4;
                    else
                        state <= after_instr;
                end
                S_T4:   state <= is_muldiv ? after_instr : S_T5;
                S_T5:   state <= (is_ld || is_st) ? S_T6 : after_instr;
                S_T6: begin
                    if (!is_ld)             state <= S_T7;
                    else if (bus.mem_done)  state <= S_T7;
                    else if (timeout)       state <= S_FAULT;
                end
                S_T7: begin
                    if (!is_st)             state <= after_instr;
                    else if (bus.mem_done)  state <= after_instr;
                    else if (timeout)       state <= S_FAULT;
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control decode from the current step (read-wait strobes also follow mem_done)
    always_comb begin
        bus.reg_sel     = '0;
        bus.reg_in      = '0;
        bus.hi_sel      = 1'b0;
        bus.low_sel     = 1'b0;
        bus.zhigh_sel   = 1'b0;
        bus.zlow_sel    = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.mdr_sel     = 1'b0;
        bus.inport_sel  = 1'b0;
        bus.c_sel       = 1'b0;
        bus.hi_in       = 1'b0;
        bus.low_in      = 1'b0;
        bus.zhigh_in    = 1'b0;
        bus.zlow_in     = 1'b0;
        bus.pc_in       = 1'b0;
        bus.mdr_in      = 1'b0;
        bus.ir_in       = 1'b0;
        bus.ry_in       = 1'b0;
        bus.rz_in       = 1'b0;
        bus.mar_in      = 1'b0;
        bus.alu_control = ALU_ADD;
        bus.md_read     = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.halted      = 1'b0;
        bus.fault       = 1'b0;
        case (state)
            S_T0: begin
                bus.pc_sel      = 1'b1;
                bus.mar_in      = 1'b1;
                bus.alu_control = ALU_INC;
                bus.zlow_in     = 1'b1;
            end
            S_T1: begin
                bus.mem_read = 1'b1;
                if (wait_cnt == '0) begin
                    bus.zlow_sel = 1'b1;
                    bus.pc_in    = 1'b1;
                end
                if (bus.mem_done) begin
                    bus.md_read = 1'b1;
                    bus.mdr_in  = 1'b1;
                end
            end
            S_T2: begin
                bus.mdr_sel = 1'b1;
                bus.ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_muldiv) begin
                    bus.reg_sel = onehot(ra);
                    bus.ry_in   = 1'b1;
                end else if (is_alu || is_addi || is_ld || is_st) begin
                    bus.reg_sel = onehot(rb);
                    bus.ry_in   = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    bus.reg_sel     = onehot(rc);
                    bus.alu_control = alu_op;
                    bus.zlow_in     = 1'b1;
                end else if (is_muldiv) begin
                    bus.reg_sel     = onehot(rb);
                    bus.alu_control = alu_op;
                    bus.hi_in       = 1'b1;
                    bus.low_in      = 1'b1;
                end else begin
                    bus.c_sel       = 1'b1;
                    bus.alu_control = ALU_ADD;
                    bus.zlow_in     = 1'b1;
                end
            end
            S_T5: begin
                bus.zlow_sel = 1'b1;
                if (is_ld || is_st) bus.mar_in = 1'b1;
                else                bus.reg_in = onehot(ra);
            end
            S_T6: begin
                if (is_ld) begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_done) begin
                        bus.md_read = 1'b1;
                        bus.mdr_in  = 1'b1;
                    end
                end else begin
                    bus.reg_sel = onehot(ra);
                    bus.mdr_in  = 1'b1;
                end
            end
            S_T7: begin
                bus.mdr_sel = 1'b1;
                if (is_st) bus.mem_write = 1'b1;
                else       bus.reg_in    = onehot(ra);
            end
            S_HALT:  bus.halted = 1'b1;
            S_FAULT: bus.fault  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: a per-instruction step listing builds the expected control
// trace, one process compares the DUT against it every cycle.
module tb_control_sequencer;
    localparam int unsigned WAIT_MAX = 15;

    typedef struct packed {
        logic [15:0] reg_sel;
        logic [15:0] reg_in;
        logic hi_sel, low_sel, zhigh_sel, zlow_sel, pc_sel, mdr_sel, inport_sel, c_sel;
        logic hi_in, low_in, zhigh_in, zlow_in, pc_in, mdr_in, ir_in, ry_in, rz_in, mar_in;
        logic [3:0] alu;
        logic md_read, mem_read, mem_write, halted, fault;
    } ctl_t;

    typedef struct packed {
        logic        run;
        logic [31:0] ir;
        logic        md;
        ctl_t        e;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;

    control_sequencer_if bus();

    control_sequencer #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    cyc_t q[$];
    ctl_t exp_cur;
    logic chk_en;
    logic cur_run;
    logic md_noise;
    int   n_checks;
    int   n_pass;
    int   cyc_no;

    task automatic check_ctl(input string name, input ctl_t act, input ctl_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    function automatic ctl_t get_act();
        ctl_t a;
        a = '0;
        a.reg_sel = bus.reg_sel;     a.reg_in = bus.reg_in;
        a.hi_sel = bus.hi_sel;       a.low_sel = bus.low_sel;
        a.zhigh_sel = bus.zhigh_sel; a.zlow_sel = bus.zlow_sel;
        a.pc_sel = bus.pc_sel;       a.mdr_sel = bus.mdr_sel;
        a.inport_sel = bus.inport_sel; a.c_sel = bus.c_sel;
        a.hi_in = bus.hi_in;         a.low_in = bus.low_in;
        a.zhigh_in = bus.zhigh_in;   a.zlow_in = bus.zlow_in;
        a.pc_in = bus.pc_in;         a.mdr_in = bus.mdr_in;
        a.ir_in = bus.ir_in;         a.ry_in = bus.ry_in;
        a.rz_in = bus.rz_in;         a.mar_in = bus.mar_in;
        a.alu = bus.alu_control;     a.md_read = bus.md_read;
        a.mem_read = bus.mem_read;   a.mem_write = bus.mem_write;
        a.halted = bus.halted;       a.fault = bus.fault;
        return a;
    endfunction

    function automatic logic [15:0] bit16(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic push(input logic [31:0] ir, input logic md, input ctl_t e);
        cyc_t c;
        c.run = cur_run; c.ir = ir; c.md = md; c.e = e;
        q.push_back(c);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push(32'h0, md_noise, '0);
    endtask

    // Step listing of one instruction; fdel/mdel = cycles memory stays busy.
    task automatic add_instr(input logic [31:0] ir, input int fdel, input int mdel);
        logic [3:0] ra, rb, rc, opc;
        int   kind;  // 0 nop, 1 reg ALU, 2 addi, 3 mul/div, 4 ld, 5 st, 6 halt
        ctl_t c;
        ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        kind = 0; opc = 4'b0000;
        case (ir[31:27])
            5'b00011: begin kind = 1; opc = 4'b0000; end
            5'b00100: begin kind = 1; opc = 4'b0001; end
            5'b00101: begin kind = 1; opc = 4'b0010; end
            5'b00110: begin kind = 1; opc = 4'b0011; end
            5'b01100: kind = 2;
            5'b01111: begin kind = 3; opc = 4'b1000; end
            5'b10000: begin kind = 3; opc = 4'b1001; end
            5'b00000: kind = 4;
            5'b00010: kind = 5;
            5'b11001: kind = 6;
            default:  kind = 0;
        endcase
        c = '0; c.pc_sel = 1; c.mar_in = 1; c.alu = 4'b1111; c.zlow_in = 1;
        push(ir, md_noise, c);
        for (int i = 0; i <= fdel; i++) begin
            c = '0; c.mem_read = 1;
            if (i == 0) begin c.zlow_sel = 1; c.pc_in = 1; end
            if (i == fdel) begin c.md_read = 1; c.mdr_in = 1; end
            push(ir, i == fdel, c);
        end
        c = '0; c.mdr_sel = 1; c.ir_in = 1;
        push(ir, md_noise, c);
        c = '0;
        if (kind == 3) begin c.reg_sel = bit16(ra); c.ry_in = 1; end
        else if (kind == 1 || kind == 2 || kind == 4 || kind == 5) begin
            c.reg_sel = bit16(rb); c.ry_in = 1;
        end
        push(ir, md_noise, c);
        if (kind == 0 || kind == 6) return;
        c = '0;
        if (kind == 1) begin c.reg_sel = bit16(rc); c.alu = opc; c.zlow_in = 1; end
        else if (kind == 3) begin c.reg_sel = bit16(rb); c.alu = opc; c.hi_in = 1; c.low_in = 1; end
        else begin c.c_sel = 1; c.alu = 4'b0000; c.zlow_in = 1; end
        push(ir, md_noise, c);
        if (kind == 3) return;
        c = '0; c.zlow_sel = 1;
        if (kind <= 2) c.reg_in = bit16(ra); else c.mar_in = 1;
        push(ir, md_noise, c);
        if (kind <= 2) return;
        if (kind == 4) begin
            for (int i = 0; i <= mdel; i++) begin
                c = '0; c.mem_read = 1;
                if (i == mdel) begin c.md_read = 1; c.mdr_in = 1; end
                push(ir, i == mdel, c);
            end
            c = '0; c.mdr_sel = 1; c.reg_in = bit16(ra);
            push(ir, md_noise, c);
        end else begin
            c = '0; c.reg_sel = bit16(ra); c.mdr_in = 1;
            push(ir, md_noise, c);
            for (int i = 0; i <= mdel; i++) begin
                c = '0; c.mdr_sel = 1; c.mem_write = 1;
                push(ir, i == mdel, c);
            end
        end
    endtask

    // Drive up to n queued cycles (n < 0: all), then drop the remainder.
    task automatic play(input int n);
        int k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge clk);
            bus.run = c.run; bus.ir = c.ir; bus.mem_done = c.md;
            exp_cur = c.e; chk_en = 1'b1; cyc_no++;
            k++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        chk_en = 1'b0; reset = 1'b0; bus.run = 1'b0; bus.mem_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Per-cycle comparison of every control against the expected trace
    always @(negedge clk) begin
        #2;
        if (chk_en) check_ctl($sformatf("cycle%0d", cyc_no), get_act(), exp_cur);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, cnt, acc;
        ctl_t c;
        n_checks = 0; n_pass = 0; chk_en = 1'b0; cyc_no = 0;
        md_noise = 1'b0; cur_run = 1'b1;
        reset = 1'b0; bus.run = 1'b0; bus.ir = '0; bus.mem_done = 1'b0;
        repeat (2) @(negedge clk);
        #2 check_ctl("reset_outputs", get_act(), '0);
        @(negedge clk);
        reset = 1'b1;

        // Main program, run held high except for the last instruction
        add_idle(1);
        s0 = q.size();
        add_instr(32'h19998000, 1, 0);
        check_int("add_len", q.size() - s0, 7);
        check_int("add_t1b_pc_in", int'(q[s0+2].e.pc_in), 0);
        check_int("add_t3_reg_sel", int'(q[s0+4].e.reg_sel), 'h0008);
        check_int("add_t5_reg_in", int'(q[s0+6].e.reg_in), 'h0008);

        s0 = q.size();
        add_instr(32'h78900000, 0, 0);
        check_int("mul_len", q.size() - s0, 5);
        check_int("mul_t3_reg_sel", int'(q[s0+3].e.reg_sel), 'h0002);
        check_int("mul_t4_reg_sel", int'(q[s0+4].e.reg_sel), 'h0004);
        check_int("mul_t4_alu", int'(q[s0+4].e.alu), 8);

        s0 = q.size();
        add_instr(mk(5'b00000, 4'd5, 4'd1, 4'd0), 0, 3);
        check_int("ld_len", q.size() - s0, 11);
        cnt = 0;
        for (int i = s0 + 6; i < q.size(); i++) cnt += int'(q[i].e.mem_read);
        check_int("ld_t6_mem_read_cycles", cnt, 4);
        check_int("ld_t6_last_mdr_in", int'(q[s0+9].e.mdr_in & q[s0+9].e.md_read), 1);
        check_int("ld_t7_reg_in", int'(q[s0+10].e.reg_in), 'h0020);

        md_noise = 1'b1;
        s0 = q.size();
        add_instr(mk(5'b00010, 4'd7, 4'd2, 4'd0), 2, 1);
        acc = 0;
        for (int i = s0; i < q.size(); i++) acc |= int'(q[i].e.reg_in);
        check_int("st_no_reg_in", acc, 0);
        check_int("st_t6_mdr_in_md_read", int'({q[s0+8].e.mdr_in, q[s0+8].e.md_read}), 2);
        add_instr(mk(5'b01100, 4'd4, 4'd6, 4'd0), 0, 0);
        md_noise = 1'b0;

        add_instr(32'h19918000, 0, 0);
        add_instr(mk(5'b00100, 4'd1, 4'd14, 4'd15), 0, 0);
        add_instr(mk(5'b00101, 4'd15, 4'd0, 4'd9), 1, 0);
        add_instr(mk(5'b10000, 4'd12, 4'd13, 4'd0), 0, 0);
        s0 = q.size();
        add_instr(mk(5'b00001, 4'd2, 4'd2, 4'd2), 0, 0);
        check_int("nop_len", q.size() - s0, 4);
        add_instr(mk(5'b00000, 4'd9, 4'd3, 4'd0), WAIT_MAX - 1, WAIT_MAX - 1);
        cur_run = 1'b0;
        add_instr(mk(5'b00110, 4'd8, 4'd9, 4'd10), 0, 0);
        add_idle(3);
        play(-1);

        // Reset pulled low while a load waits on memory
        cur_run = 1'b1;
        add_idle(1);
        add_instr(mk(5'b00000, 4'd2, 4'd3, 4'd0), 0, 10);
        play(9);
        #3;
        check_int("pre_reset_mem_read", int'(bus.mem_read), 1);
        chk_en = 1'b0; reset = 1'b0; bus.run = 1'b0;
        #1;
        check_int("async_mem_read", int'(bus.mem_read), 0);
        check_ctl("async_all_zero", get_act(), '0);
        @(negedge clk);
        reset = 1'b1;
        add_idle(1);
        add_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 0);
        play(-1);

        // Fetch that memory never completes
        do_reset();
        cur_run = 1'b1;
        add_idle(1);
        c = '0; c.pc_sel = 1; c.mar_in = 1; c.alu = 4'b1111; c.zlow_in = 1;
        push(32'h19998000, 1'b0, c);
        for (int i = 0; i < int'(WAIT_MAX); i++) begin
            c = '0; c.mem_read = 1;
            if (i == 0) begin c.zlow_sel = 1; c.pc_in = 1; end
            push(32'h19998000, 1'b0, c);
        end
        for (int i = 0; i < 4; i++) begin
            cur_run = 1'(i % 2);
            c = '0; c.fault = 1;
            push(32'h19998000, 1'(i % 2), c);
        end
        play(-1);

        // HALT holds regardless of run and mem_done
        do_reset();
        cur_run = 1'b1;
        add_idle(1);
        add_instr(mk(5'b11001, 4'd0, 4'd0, 4'd0), 0, 0);
        for (int i = 0; i < 6; i++) begin
            cur_run = 1'(i % 2);
            c = '0; c.halted = 1;
            push(mk(5'b11001, 4'd0, 4'd0, 4'd0), 1'((i + 1) % 2), c);
        end
        play(-1);

        @(negedge clk);
        chk_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
